// File: rtl/fifo_reader_if.sv
// fifo_reader_if -- bundle of the FIFO-side and stream-side signals of fifo_reader.
//
// Signals:
//   buf_out      FIFO read data, valid the cycle after a rd_en on a non-empty FIFO
//   buf_empty    FIFO empty flag
//   fifo_counter FIFO occupancy
//   rd_en        FIFO read request (driven by the reader)
//   dout         output stream data (driven by the reader)
//   dout_valid   dout holds a valid byte (driven by the reader)
//   dout_ready   downstream accepts dout this cycle
//   rd_count     count of completed dout handshakes (driven by the reader)
//
// Modports:
//   master  the reader block
//   slave   the environment (FIFO plus downstream consumer)

interface fifo_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] buf_out;
    logic                  buf_empty;
    logic [7:0]            fifo_counter;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [15:0]           rd_count;

    modport master (
        input  buf_out,
        input  buf_empty,
        input  fifo_counter,
        input  dout_ready,
        output rd_en,
        output dout,
        output dout_valid,
        output rd_count
    );

    modport slave (
        output buf_out,
        output buf_empty,
        output fifo_counter,
        output dout_ready,
        input  rd_en,
        input  dout,
        input  dout_valid,
        input  rd_count
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader -- drains a synchronous FIFO into a valid/ready output stream.
//
// A FIFO read issued with rd_en returns data on buf_out one cycle later; that
// byte is captured into a 2-entry output buffer whose head drives dout.
// Reads are throttled so that buffered plus in-flight bytes never exceed the
// buffer depth, so no byte is ever dropped under backpressure.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   fifo_reader_if.master (buf_out, buf_empty, fifo_counter, dout_ready
//         in; rd_en, dout, dout_valid, rd_count out)
//
// Parameters:
//   DATA_WIDTH  width of buf_out and dout
//   BURST_LEN   reads per burst in burst mode (1..255)
//
// Build option:
//   FIFO_RD_BURST_EN  when defined, reading starts only once fifo_counter
//                     reaches BURST_LEN and stops after exactly BURST_LEN
//                     reads (stalling in READ if the FIFO runs dry).
//                     When undefined, the reader follows buf_empty directly.
//
// States:
//   state | meaning
//   IDLE  | no reads issued; waiting for a start condition
//   READ  | issuing reads whenever the FIFO has data and the buffer has room

module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_reader_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LEN_B = 8'(BURST_LEN);

    state_t                state;
    logic [1:0]            occ;
    logic                  infl;
    logic [DATA_WIDTH-1:0] mem0;
    logic [DATA_WIDTH-1:0] mem1;
    logic [15:0]           rd_count_q;

    logic                  rd_en_c;
    logic                  pop;
    logic                  cap;

`ifdef FIFO_RD_BURST_EN
    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);
    logic [7:0]            beat_cnt;
`else
    // fifo_counter and the burst length only matter in burst mode.
    logic                  unused_cfg;
    assign unused_cfg = ^{bus.fifo_counter, BURST_LEN_B};
`endif

    // Buffered plus in-flight bytes must stay below the buffer depth, so a
    // read is only issued when its returning byte is guaranteed a slot.
    assign rd_en_c = (state == READ) && !bus.buf_empty &&
                     (({1'b0, occ} + {2'b00, infl}) < 3'd2);

    assign pop = (occ != 2'd0) && bus.dout_ready;
    assign cap = infl;

    assign bus.rd_en      = rd_en_c;
    assign bus.dout       = mem0;
    assign bus.dout_valid = (occ != 2'd0);
    assign bus.rd_count   = rd_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            occ        <= 2'd0;
            infl       <= 1'b0;
            mem0       <= '0;
            mem1       <= '0;
            rd_count_q <= 16'd0;
`ifdef FIFO_RD_BURST_EN
            beat_cnt   <= 8'd0;
`endif
        end else begin
            infl <= rd_en_c;

            if (pop) begin
                rd_count_q <= rd_count_q + 16'd1;
            end

            // mem0 is always the head; a pop shifts mem1 forward, and a
            // capture lands in the first slot left free after any pop.
            case ({cap, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        mem0 <= bus.buf_out;
                        occ  <= 2'd1;
                    end else if (occ == 2'd1) begin
                        mem1 <= bus.buf_out;
                        occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    mem0 <= mem1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        mem0 <= bus.buf_out;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= bus.buf_out;
                    end
                end
                default: begin
                end
            endcase

`ifdef FIFO_RD_BURST_EN
            case (state)
                IDLE: begin
                    if (bus.fifo_counter >= BURST_LEN_B) begin
                        state    <= READ;
                        beat_cnt <= 8'd0;
                    end
                end
                READ: begin
                    if (rd_en_c) begin
                        if (beat_cnt == BURST_LAST) begin
                            state    <= IDLE;
                            beat_cnt <= 8'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`else
            case (state)
                IDLE: begin
                    if (!bus.buf_empty) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (bus.buf_empty) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_reader_if #(.DATA_WIDTH(8)) bus ();

    fifo_reader #(
        .DATA_WIDTH(8),
        .BURST_LEN (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: read data appears on buf_out the cycle after rd_en.
    logic [7:0] fq [0:63];
    int         wr_p = 0;
    int         rd_p = 0;

    // Observed output stream and read-request statistics.
    logic [7:0] rx [0:63];
    int         rx_n      = 0;
    int         rd_pulses = 0;
    int         viol      = 0;

    int         n_checks = 0;
    int         n_err    = 0;

    assign bus.buf_empty    = (wr_p == rd_p);
    assign bus.fifo_counter = 8'(wr_p - rd_p);

    always @(posedge clk) begin
        if (!rst) begin
            rd_p <= wr_p;
        end else begin
            if (bus.rd_en) begin
                rd_pulses <= rd_pulses + 1;
                if (wr_p == rd_p) begin
                    viol <= viol + 1;
                end else begin
                    bus.buf_out <= fq[rd_p[5:0]];
                    rd_p        <= rd_p + 1;
                end
            end
            if (bus.dout_valid && bus.dout_ready) begin
                rx[rx_n[5:0]] <= bus.dout;
                rx_n          <= rx_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq[wr_p[5:0]] = b;
        wr_p = wr_p + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rx(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (rx_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(rx_n), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_p;
        int rx_base;

        bus.dout_ready = 1'b1;
        rst            = 1'b0;
        #1;
        chk("reset_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("reset_rd_en", 32'(bus.rd_en), 32'd0);
        chk("reset_rd_count", 32'(bus.rd_count), 32'd0);
        chk("reset_dout", 32'(bus.dout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_empty_rd_en", 32'(bus.rd_en), 32'd0);

`ifdef FIFO_RD_BURST_EN
        // Three bytes are below the burst threshold: nothing may be read.
        push(8'h01); push(8'h02); push(8'h03);
        cycles(6);
        chk("burst_below_pulses", 32'(rd_pulses), 32'd0);
        chk("burst_below_state", 32'(dut.state), 32'd0);
        chk("burst_below_rd_en", 32'(bus.rd_en), 32'd0);
        push(8'h04);
        wait_rx(4, 40, "burst_rx_count");
        cycles(3);
        chk("burst_pulses", 32'(rd_pulses), 32'd4);
        chk("burst_state_idle", 32'(dut.state), 32'd0);
        chk("burst_b0", 32'(rx[0]), 32'h01);
        chk("burst_b1", 32'(rx[1]), 32'h02);
        chk("burst_b2", 32'(rx[2]), 32'h03);
        chk("burst_b3", 32'(rx[3]), 32'h04);
        chk("burst_rd_count", 32'(bus.rd_count), 32'd4);
        chk("burst_viol", 32'(viol), 32'd0);
`else
        // Streaming: three preloaded bytes, downstream always ready.
        push(8'h11); push(8'h22); push(8'h33);
        @(negedge clk);
        chk("stream_first_rd_en", 32'(bus.rd_en), 32'd1);
        chk("stream_c1_valid", 32'(bus.dout_valid), 32'd0);
        @(negedge clk);
        chk("stream_c2_valid", 32'(bus.dout_valid), 32'd0);
        @(negedge clk);
        chk("stream_c3_valid", 32'(bus.dout_valid), 32'd1);
        chk("stream_c3_dout", 32'(bus.dout), 32'h11);
        @(negedge clk);
        chk("stream_c4_dout", 32'(bus.dout), 32'h22);
        wait_rx(3, 30, "stream_rx_count");
        cycles(3);
        chk("stream_b0", 32'(rx[0]), 32'h11);
        chk("stream_b1", 32'(rx[1]), 32'h22);
        chk("stream_b2", 32'(rx[2]), 32'h33);
        chk("stream_rd_count", 32'(bus.rd_count), 32'd3);
        chk("stream_pulses", 32'(rd_pulses), 32'd3);
        chk("stream_state_idle", 32'(dut.state), 32'd0);

        // Backpressure: only two reads fit in the buffer.
        bus.dout_ready = 1'b0;
        base_p = rd_pulses;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
        cycles(8);
        chk("bp_pulses", 32'(rd_pulses - base_p), 32'd2);
        chk("bp_occ", 32'(dut.occ), 32'd2);
        chk("bp_valid", 32'(bus.dout_valid), 32'd1);
        chk("bp_dout", 32'(bus.dout), 32'hA1);
        cycles(3);
        chk("bp_dout_stable", 32'(bus.dout), 32'hA1);
        chk("bp_no_extra_rd", 32'(rd_pulses - base_p), 32'd2);
        bus.dout_ready = 1'b1;
        wait_rx(8, 40, "bp_rx_count");
        cycles(4);
        chk("bp_b0", 32'(rx[3]), 32'hA1);
        chk("bp_b1", 32'(rx[4]), 32'hA2);
        chk("bp_b2", 32'(rx[5]), 32'hA3);
        chk("bp_b3", 32'(rx[6]), 32'hA4);
        chk("bp_b4", 32'(rx[7]), 32'hA5);
        chk("bp_rd_count", 32'(bus.rd_count), 32'd8);
        chk("bp_state_idle", 32'(dut.state), 32'd0);

        // Reset mid-stream clears outputs without a clock edge.
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        cycles(3);
        chk("mid_pre_valid", 32'(bus.dout_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("mid_rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("mid_rst_rd_count", 32'(bus.rd_count), 32'd0);
        chk("mid_rst_dout", 32'(bus.dout), 32'd0);
        chk("mid_rst_occ", 32'(dut.occ), 32'd0);
        chk("mid_rst_infl", 32'(dut.infl), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycles(3);
        chk("post_rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("post_rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("post_rst_state", 32'(dut.state), 32'd0);

        // Single byte written while idle.
        base_p  = rd_pulses;
        rx_base = rx_n;
        push(8'h5C);
        wait_rx(rx_base + 1, 20, "single_rx_count");
        cycles(4);
        chk("single_pulses", 32'(rd_pulses - base_p), 32'd1);
        chk("single_byte", 32'(rx[rx_base[5:0]]), 32'h5C);
        chk("single_no_dup", 32'(rx_n), 32'(rx_base + 1));
        chk("single_rd_count", 32'(bus.rd_count), 32'd1);
        chk("no_rd_while_empty", 32'(viol), 32'd0);

        // rd_count wraps after 0xFFFF handshakes.
        dut.rd_count_q = 16'hFFFF;
        push(8'h77);
        wait_rx(rx_base + 2, 20, "wrap_rx_count");
        cycles(2);
        chk("wrap_rd_count", 32'(bus.rd_count), 32'h0000);
        chk("wrap_byte", 32'(rx[6'(rx_base + 1)]), 32'h77);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
